// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 constants, FSM encoding and access-legality helper for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // Stores only know B/H/W; loads additionally have BU/HU.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/half of a load word and sign/zero-extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I memory stage: req/gnt/rvalid data port, load align, one result per instruction
// LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of truncating the low address bits.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int RD_W      = 5,
  parameter int TIMEOUT_W = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_res,
  input  logic [31:0]     in_wdata,
  input  logic [2:0]      in_funct3,
  input  logic            in_is_load,
  input  logic            in_is_store,
  input  logic            in_wen,
  input  logic [RD_W-1:0] in_rd,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic            out_valid,
  output logic            out_wen,
  output logic [RD_W-1:0] out_rd,
  output logic [31:0]     out_data,
  output logic            out_err
);

  if (TIMEOUT_W != 0) begin : g_timeout_unsupported
    $error("load_store_unit: TIMEOUT_W must be 0");
  end

  lsu_state_e state_q, state_d;

  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic            is_load_q;
  logic [RD_W-1:0] rd_q;
  logic            mem_we_q;
  logic [3:0]      mem_be_q;
  logic [31:0]     mem_addr_q, mem_wdata_q;
  logic            out_wen_q, out_err_q;
  logic [RD_W-1:0] out_rd_q;
  logic [31:0]     out_data_q;

  logic        is_mem, trap, access_err, go_done;
  logic [1:0]  off_eff;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_val;

  assign is_mem = in_is_load | in_is_store;

  // Offset actually used for lanes: half ignores bit 0, word ignores both.
  always_comb begin
    off_eff = in_res[1:0];
    case (in_funct3[1:0])
      2'b01:   off_eff = {in_res[1], 1'b0};
      2'b10:   off_eff = 2'b00;
      default: off_eff = in_res[1:0];
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    trap = 1'b0;
    case (in_funct3[1:0])
      2'b01:   trap = is_mem & in_res[0];
      2'b10:   trap = is_mem & (|in_res[1:0]);
      default: trap = 1'b0;
    endcase
  end
`else
  assign trap = 1'b0;
`endif

  assign access_err = (in_is_load & in_is_store)
                    | (is_mem & f3_illegal(in_is_store, in_funct3))
                    | trap;
  assign go_done    = access_err | ~is_mem;

  always_comb begin
    be_d    = 4'hF;
    wdata_d = in_wdata;
    case (in_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << off_eff;
        wdata_d = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << off_eff;
        wdata_d = {2{in_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'hF;
        wdata_d = in_wdata;
      end
    endcase
  end

  lsu_load_align u_load_align (
    .rdata_i  (mem_rdata),
    .offset_i (off_q),
    .funct3_i (funct3_q),
    .data_o   (load_val)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = go_done ? DONE : REQ;
      REQ:     if (mem_gnt) state_d = is_load_q ? WAIT : DONE;
      WAIT:    if (mem_rvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    mem_req   = (state_q == REQ);
    out_valid = (state_q == DONE);
  end

  // out_* only change on entry to DONE so they hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q    <= '0;
      off_q       <= '0;
      is_load_q   <= 1'b0;
      rd_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_wen_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          funct3_q    <= in_funct3;
          off_q       <= off_eff;
          is_load_q   <= in_is_load;
          rd_q        <= in_rd;
          mem_we_q    <= in_is_store;
          mem_be_q    <= be_d;
          mem_addr_q  <= {in_res[31:2], 2'b00};
          mem_wdata_q <= wdata_d;
          if (go_done) begin
            out_data_q <= in_res;
            out_wen_q  <= in_wen & ~access_err;
            out_err_q  <= access_err;
            out_rd_q   <= in_rd;
          end
        end
        REQ: if (mem_gnt && !is_load_q) begin
          out_wen_q <= 1'b0;
          out_err_q <= 1'b0;
          out_rd_q  <= rd_q;
        end
        WAIT: if (mem_rvalid) begin
          out_data_q <= load_val;
          out_wen_q  <= 1'b1;
          out_err_q  <= 1'b0;
          out_rd_q   <= rd_q;
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign out_wen   = out_wen_q;
  assign out_err   = out_err_q;
  assign out_rd    = out_rd_q;
  assign out_data  = out_data_q;

endmodule
